// File: rtl/iter_shifter.sv
// iter_shifter: multi-cycle shift/rotate unit for the RV32I execute stage.
// Accepts one op per req handshake, shifts 1 bit/cycle (4 with STEP4).
//
// Build option: define ITER_SHIFTER_STEP4_EN to step by 4 while count >= 4.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/ready     request handshake (ready only in IDLE)
//   req_data            operand
//   req_amount          shift/rotate distance
//   req_left1_right0    direction
//   req_arith1_logic0   sign fill for right shifts
//   req_shift1_rotate0  shift vs rotate
//   resp_valid/ready    response handshake
//   resp_data           registered result
//   busy                high while an op is in flight (RUN or DONE)
module iter_shifter #(
  parameter  int BitWidth = 32,
  localparam int log_bw   = $clog2(BitWidth)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [BitWidth-1:0] req_data,
  input  logic [log_bw-1:0]   req_amount,
  input  logic                req_left1_right0,
  input  logic                req_arith1_logic0,
  input  logic                req_shift1_rotate0,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [BitWidth-1:0] resp_data,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [BitWidth-1:0] data_q, data_d;
  logic [BitWidth-1:0] stepped, fmask;
  logic [log_bw-1:0]   count_q, count_d;
  logic [log_bw-1:0]   s;
  logic                left_q, left_d;
  logic                shift_q, shift_d;
  logic                fill_q, fill_d;

  // Step distance for this RUN cycle.
  always_comb begin
`ifdef ITER_SHIFTER_STEP4_EN
    s = (count_q > log_bw'(3)) ? log_bw'(4)
                               : log_bw'(1);
`else
    s = log_bw'(1);
`endif
  end

  // One step of the captured op; s is only ever 1 or 4.
  always_comb begin
    fmask   = {BitWidth{fill_q}}
            & ~({BitWidth{1'b1}} >> s);
    stepped = data_q;
    unique case (1'b1)
      (shift_q && left_q):
        stepped = data_q << s;
      (shift_q && !left_q):
        stepped = (data_q >> s) | fmask;
      (!shift_q && left_q):
        stepped = (data_q << s)
                | (data_q >> (BitWidth - int'(s)));
      default:
        stepped = (data_q >> s)
                | (data_q << (BitWidth - int'(s)));
    endcase
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    count_d = count_q;
    left_d  = left_q;
    shift_d = shift_q;
    fill_d  = fill_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          data_d  = req_data;
          count_d = req_amount;
          left_d  = req_left1_right0;
          shift_d = req_shift1_rotate0;
          // Sign fill only for arithmetic right shifts.
          fill_d  = req_arith1_logic0
                  & ~req_left1_right0
                  & req_shift1_rotate0
                  & req_data[BitWidth-1];
          state_d = (req_amount != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        data_d  = stepped;
        count_d = count_q - s;
        if (count_q == s) state_d = DONE;
      end
      DONE: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      count_q <= '0;
      left_q  <= 1'b0;
      shift_q <= 1'b0;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
      left_q  <= left_d;
      shift_q <= shift_d;
      fill_q  <= fill_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign resp_data  = data_q;

endmodule

// File: tb/tb_iter_shifter.sv
// tb_iter_shifter: directed self-checking bench for iter_shifter.
// Linear sequence of ops with hand-computed results and latencies.
module tb_iter_shifter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_data;
  logic [4:0]  req_amount;
  logic        req_left1_right0;
  logic        req_arith1_logic0;
  logic        req_shift1_rotate0;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  iter_shifter #(.BitWidth(32)) dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_data          (req_data),
    .req_amount        (req_amount),
    .req_left1_right0  (req_left1_right0),
    .req_arith1_logic0 (req_arith1_logic0),
    .req_shift1_rotate0(req_shift1_rotate0),
    .resp_valid        (resp_valid),
    .resp_ready        (resp_ready),
    .resp_data         (resp_data),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag,
                     logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h want %h",
             tag, obs, exp);
    end
  endtask

  function automatic int lat_of(int a);
`ifdef ITER_SHIFTER_STEP4_EN
    return a / 4 + a % 4 + 1;
`else
    return a + 1;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, wait for the response, check
  // value/latency/busy, then complete the handshake.
  task automatic run_op(string tag,
                        logic [31:0] d,
                        logic [4:0] a,
                        logic l, logic ar, logic sh,
                        logic [31:0] exp,
                        bit churn);
    int lat;
    bit bsy;
    chk({tag, ".rdy"}, 32'(req_ready), 32'd1);
    req_data           = d;
    req_amount         = a;
    req_left1_right0   = l;
    req_arith1_logic0  = ar;
    req_shift1_rotate0 = sh;
    req_valid          = 1'b1;
    tick();
    req_valid = churn;
    lat = 1;
    bsy = 1'b1;
    while (!resp_valid && lat < 100) begin
      bsy &= busy;
      if (churn) begin
        req_data   = $urandom;
        req_amount = 5'($urandom);
        req_left1_right0 = ~req_left1_right0;
      end
      tick();
      lat++;
    end
    req_valid = 1'b0;
    bsy &= busy;
    chk({tag, ".lat"}, 32'(lat), 32'(lat_of(a)));
    chk({tag, ".data"}, resp_data, exp);
    chk({tag, ".busy"}, 32'(bsy), 32'd1);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk({tag, ".vld0"}, 32'(resp_valid), 32'd0);
    chk({tag, ".rdy1"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] held;
    bit seen;
    rst                = 1'b1;
    req_valid          = 1'b0;
    req_data           = '0;
    req_amount         = '0;
    req_left1_right0   = 1'b0;
    req_arith1_logic0  = 1'b0;
    req_shift1_rotate0 = 1'b0;
    resp_ready         = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst.rdy",  32'(req_ready),  32'd1);
    chk("rst.vld",  32'(resp_valid), 32'd0);
    chk("rst.data", resp_data,       32'h0);
    chk("rst.busy", 32'(busy),       32'd0);

    // tag, data, amt, left, arith, shift, expected
    run_op("sra4", 32'h8000_0001, 5'd4,
           1'b0, 1'b1, 1'b1, 32'hF800_0000, 1'b0);
    run_op("srl31", 32'h8000_0001, 5'd31,
           1'b0, 1'b0, 1'b1, 32'h0000_0001, 1'b0);
    run_op("rol1", 32'h8000_0001, 5'd1,
           1'b1, 1'b0, 1'b0, 32'h0000_0003, 1'b0);
    run_op("ror1", 32'h8000_0001, 5'd1,
           1'b0, 1'b0, 1'b0, 32'hC000_0000, 1'b0);
    run_op("ror1a", 32'h8000_0001, 5'd1,
           1'b0, 1'b1, 1'b0, 32'hC000_0000, 1'b0);
    run_op("sll31", 32'h0000_0001, 5'd31,
           1'b1, 1'b0, 1'b1, 32'h8000_0000, 1'b0);
    run_op("sra5p", 32'h7000_0000, 5'd5,
           1'b0, 1'b1, 1'b1, 32'h0380_0000, 1'b0);
    run_op("slla", 32'hF000_000F, 5'd4,
           1'b1, 1'b1, 1'b1, 32'h0000_00F0, 1'b0);
    run_op("rol8", 32'h1234_5678, 5'd8,
           1'b1, 1'b0, 1'b0, 32'h3456_7812, 1'b0);
    run_op("ror7", 32'h1234_5678, 5'd7,
           1'b0, 1'b0, 1'b0, 32'hF024_68AC, 1'b0);
    run_op("sra31", 32'h8000_0000, 5'd31,
           1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);
    run_op("churn", 32'h0000_0001, 5'd8,
           1'b1, 1'b0, 1'b1, 32'h0000_0100, 1'b1);

    // Amount 0 with backpressure.
    req_data           = 32'hDEAD_BEEF;
    req_amount         = 5'd0;
    req_left1_right0   = 1'b1;
    req_arith1_logic0  = 1'b0;
    req_shift1_rotate0 = 1'b1;
    req_valid          = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("z.vld",  32'(resp_valid), 32'd1);
    chk("z.data", resp_data, 32'hDEAD_BEEF);
    held = resp_data;
    req_valid  = 1'b1;
    req_data   = 32'h1111_2222;
    req_amount = 5'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp.data", resp_data, held);
      chk("bp.vld",  32'(resp_valid), 32'd1);
      chk("bp.rdy",  32'(req_ready),  32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("bp.rdy1", 32'(req_ready),  32'd1);
    chk("bp.vld0", 32'(resp_valid), 32'd0);
    chk("bp.busy", 32'(busy),       32'd0);

    // Reset in the middle of a long RUN.
    req_data           = 32'h0000_0001;
    req_amount         = 5'd20;
    req_left1_right0   = 1'b1;
    req_shift1_rotate0 = 1'b1;
    req_valid          = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("mr.busy1", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr.rdy",  32'(req_ready),  32'd1);
    chk("mr.vld",  32'(resp_valid), 32'd0);
    chk("mr.data", resp_data,       32'h0);
    chk("mr.busy", 32'(busy),       32'd0);
    resp_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      seen |= resp_valid | busy;
      tick();
    end
    resp_ready = 1'b0;
    chk("mr.stale", 32'(seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
